// File: rtl/fa_nbit_arb_ctrl_if.sv
// Requester and adder-side signal bundle for fa_nbit_arb_ctrl.
// Optional R_OVF member is present only when FA_ARB_OVF_FLAG_EN is defined.
interface fa_nbit_arb_ctrl_if #(
    parameter int SIZE = 16
);
    logic            req0;
    logic [SIZE-1:0] A0;
    logic [SIZE-1:0] B0;
    logic            CI0;
    logic            req1;
    logic [SIZE-1:0] A1;
    logic [SIZE-1:0] B1;
    logic            CI1;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic [SIZE-1:0] R_SUM;
    logic            R_CO;
`ifdef FA_ARB_OVF_FLAG_EN
    logic            R_OVF;
`endif
    logic [SIZE-1:0] add_I;
    logic            add_En;
    logic            add_CI;
    logic            add_sel;
    logic [SIZE-1:0] add_SUM;
    logic            add_CO;

    // Controller side.
    modport slave (
        input  req0, A0, B0, CI0, req1, A1, B1, CI1, add_SUM, add_CO,
`ifdef FA_ARB_OVF_FLAG_EN
        output R_OVF,
`endif
        output gnt, done, R_SUM, R_CO, add_I, add_En, add_CI, add_sel
    );

    // Requesters plus the shared adder.
    modport master (
        output req0, A0, B0, CI0, req1, A1, B1, CI1, add_SUM, add_CO,
`ifdef FA_ARB_OVF_FLAG_EN
        input  R_OVF,
`endif
        input  gnt, done, R_SUM, R_CO, add_I, add_En, add_CI, add_sel
    );
endinterface

// File: rtl/fa_nbit_arb_ctrl.sv
// Round-robin controller sharing one FA_NBIT adder between two requesters.
// Define FA_ARB_OVF_FLAG_EN to add the registered signed-overflow flag R_OVF.
module fa_nbit_arb_ctrl #(
    parameter int SIZE = 16
) (
    input  logic              clk,
    input  logic              rst,
    fa_nbit_arb_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADA,
        S_ADDB,
        S_CAPT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_w;
    logic            r_last;
    logic [1:0]      r_gnt;
    logic [1:0]      r_done;
    logic [SIZE-1:0] r_sum;
    logic            r_co;
    logic [SIZE-1:0] r_add_i;
    logic            r_add_en;
    logic            r_add_ci;
    logic            r_add_sel;
`ifdef FA_ARB_OVF_FLAG_EN
    logic            r_a_msb;
    logic            r_b_msb;
    logic            r_ovf;
`endif

    logic            w_any_req;
    logic            w_win;
    logic            w_port;
    logic [SIZE-1:0] w_a;
    logic [SIZE-1:0] w_b;
    logic            w_ci;

    // Tie goes to the port that was not served last.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no latch is inferred.
        w_any_req = bus.req0 | bus.req1;
        w_win     = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
        w_port    = (r_state == S_IDLE) ? w_win : r_w;
        w_a       = w_port ? bus.A1  : bus.A0;
        w_b       = w_port ? bus.B1  : bus.B0;
        w_ci      = w_port ? bus.CI1 : bus.CI0;
    end

    // Each state's adder controls are registered on entry, so the adder sees them one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_w       <= 1'b0;
            r_last    <= 1'b1;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_sum     <= '0;
            r_co      <= 1'b0;
            r_add_i   <= '0;
            r_add_en  <= 1'b0;
            r_add_ci  <= 1'b0;
            r_add_sel <= 1'b0;
`ifdef FA_ARB_OVF_FLAG_EN
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
            r_ovf     <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
            case (r_state)
                S_IDLE: begin
                    r_add_en <= 1'b0;
                    if (w_any_req) begin
                        r_w       <= w_win;
                        r_gnt     <= w_win ? 2'b10 : 2'b01;
                        r_add_i   <= w_a;
                        r_add_ci  <= 1'b0;
                        r_add_sel <= 1'b0;
                        r_add_en  <= 1'b1;
                        r_state   <= S_LOADA;
                    end
                end
                S_LOADA: begin
`ifdef FA_ARB_OVF_FLAG_EN
                    r_a_msb   <= r_add_i[SIZE-1];
`endif
                    r_add_i   <= w_b;
                    r_add_ci  <= w_ci;
                    r_add_sel <= 1'b1;
                    r_add_en  <= 1'b1;
                    r_state   <= S_ADDB;
                end
                S_ADDB: begin
`ifdef FA_ARB_OVF_FLAG_EN
                    r_b_msb  <= r_add_i[SIZE-1];
`endif
                    r_add_en <= 1'b0;
                    r_state  <= S_CAPT;
                end
                S_CAPT: begin
                    r_sum   <= bus.add_SUM;
                    r_co    <= bus.add_CO;
`ifdef FA_ARB_OVF_FLAG_EN
                    r_ovf   <= (r_a_msb == r_b_msb) && (bus.add_SUM[SIZE-1] != r_a_msb);
`endif
                    r_done  <= r_w ? 2'b10 : 2'b01;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 2'b00;
                    r_gnt   <= 2'b00;
                    r_last  <= r_w;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.R_SUM   = r_sum;
    assign bus.R_CO    = r_co;
    assign bus.add_I   = r_add_i;
    assign bus.add_En  = r_add_en;
    assign bus.add_CI  = r_add_ci;
    assign bus.add_sel = r_add_sel;
`ifdef FA_ARB_OVF_FLAG_EN
    assign bus.R_OVF   = r_ovf;
`endif

endmodule

// File: tb/tb_fa_nbit_arb_ctrl.sv
// Directed bench for fa_nbit_arb_ctrl with a behavioural FA_NBIT adder attached.
// Checks R_OVF as well when built with FA_ARB_OVF_FLAG_EN.
module tb_fa_nbit_arb_ctrl;
    localparam int SIZE = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fa_nbit_arb_ctrl_if #(.SIZE(SIZE)) bus ();

    fa_nbit_arb_ctrl #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared adder: sel=0 stores A, sel=1 registers A+I+CI.
    logic [SIZE-1:0] m_a;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a         <= '0;
            bus.add_SUM <= '0;
            bus.add_CO  <= 1'b0;
        end else if (bus.add_En) begin
            if (!bus.add_sel)
                m_a <= bus.add_I;
            else
                {bus.add_CO, bus.add_SUM} <= {1'b0, m_a} + {1'b0, bus.add_I}
                                             + {{SIZE{1'b0}}, bus.add_CI};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef FA_ARB_OVF_FLAG_EN
        check(tag, 32'(bus.R_OVF), 32'(exp));
`endif
    endtask

    // Request must already be high before the sampling edge; returns at the done negedge.
    task automatic service(input int p, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                           input logic ci, input logic [SIZE-1:0] exp_sum, input logic exp_co,
                           input logic exp_ovf, input bit drop);
        logic [1:0] exp_g;
        exp_g = (p == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        check("gnt_loada", 32'(bus.gnt), 32'(exp_g));
        check("done_loada", 32'(bus.done), 32'd0);
        check("en_loada", 32'(bus.add_En), 32'd1);
        check("sel_loada", 32'(bus.add_sel), 32'd0);
        check("i_loada", 32'(bus.add_I), 32'(a));
        if (drop) begin
            if (p == 1) bus.req1 = 1'b0;
            else        bus.req0 = 1'b0;
        end
        @(negedge clk);
        check("gnt_addb", 32'(bus.gnt), 32'(exp_g));
        check("sel_addb", 32'(bus.add_sel), 32'd1);
        check("i_addb", 32'(bus.add_I), 32'(b));
        check("ci_addb", 32'(bus.add_CI), 32'(ci));
        check("done_addb", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("en_capt", 32'(bus.add_En), 32'd0);
        check("done_capt", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'(exp_g));
        check("gnt_done", 32'(bus.gnt), 32'(exp_g));
        check("r_sum", 32'(bus.R_SUM), 32'(exp_sum));
        check("r_co", 32'(bus.R_CO), 32'(exp_co));
        check_ovf("r_ovf", exp_ovf);
    endtask

    task automatic idle_gap(input logic [SIZE-1:0] exp_sum);
        @(negedge clk);
        check("gap_gnt", 32'(bus.gnt), 32'd0);
        check("gap_done", 32'(bus.done), 32'd0);
        check("gap_hold_sum", 32'(bus.R_SUM), 32'(exp_sum));
    endtask

    initial begin
        bus.req0 = 1'b0; bus.A0 = '0; bus.B0 = '0; bus.CI0 = 1'b0;
        bus.req1 = 1'b0; bus.A1 = '0; bus.B1 = '0; bus.CI1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.R_SUM), 32'd0);
        check("rst_co", 32'(bus.R_CO), 32'd0);
        check("rst_en", 32'(bus.add_En), 32'd0);
        check("rst_i", 32'(bus.add_I), 32'd0);
        check_ovf("rst_ovf", 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single requests on each port, then unsigned wrap-around.
        bus.req0 = 1'b1; bus.A0 = 16'd500; bus.B0 = 16'd400; bus.CI0 = 1'b0;
        service(0, 16'd500, 16'd400, 1'b0, 16'd900, 1'b0, 1'b0, 1'b0);
        bus.req0 = 1'b0;
        idle_gap(16'd900);
        bus.req1 = 1'b1; bus.A1 = 16'd400; bus.B1 = 16'd400; bus.CI1 = 1'b1;
        service(1, 16'd400, 16'd400, 1'b1, 16'd801, 1'b0, 1'b0, 1'b0);
        bus.req1 = 1'b0;
        idle_gap(16'd801);
        bus.req0 = 1'b1; bus.A0 = 16'd32800; bus.B0 = 16'd32800; bus.CI0 = 1'b0;
        service(0, 16'd32800, 16'd32800, 1'b0, 16'd64, 1'b1, 1'b1, 1'b0);
        bus.req0 = 1'b0;
        idle_gap(16'd64);

        // Fresh reset, both held: alternation 0,1,0,1 with 5-cycle done spacing.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b1; bus.A0 = 16'd10; bus.B0 = 16'd20; bus.CI0 = 1'b0;
        bus.req1 = 1'b1; bus.A1 = 16'd3;  bus.B1 = 16'd5;  bus.CI1 = 1'b1;
        service(0, 16'd10, 16'd20, 1'b0, 16'd30, 1'b0, 1'b0, 1'b0);
        idle_gap(16'd30);
        service(1, 16'd3, 16'd5, 1'b1, 16'd9, 1'b0, 1'b0, 1'b0);
        idle_gap(16'd9);
        service(0, 16'd10, 16'd20, 1'b0, 16'd30, 1'b0, 1'b0, 1'b0);
        idle_gap(16'd30);
        service(1, 16'd3, 16'd5, 1'b1, 16'd9, 1'b0, 1'b0, 1'b0);

        // Reset during ADDB discards the operation; pending req0 is re-served.
        bus.req1 = 1'b0; bus.A0 = 16'd3; bus.B0 = 16'd5; bus.CI0 = 1'b0;
        idle_gap(16'd9);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_addb_sel", 32'(bus.add_sel), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_gnt", 32'(bus.gnt), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_sum", 32'(bus.R_SUM), 32'd0);
        check("midrst_en", 32'(bus.add_En), 32'd0);
        check("midrst_sel", 32'(bus.add_sel), 32'd0);
        check("midrst_i", 32'(bus.add_I), 32'd0);
        @(negedge clk);
        check("inrst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        service(0, 16'd3, 16'd5, 1'b0, 16'd8, 1'b0, 1'b0, 1'b0);

        // Serve port 1, then port 0 with req dropped in LOADA; the next tie must go to port 1.
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.A1 = 16'd1; bus.B1 = 16'd2; bus.CI1 = 1'b0;
        idle_gap(16'd8);
        service(1, 16'd1, 16'd2, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0);
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.A0 = 16'd7; bus.B0 = 16'd8; bus.CI0 = 1'b1;
        idle_gap(16'd3);
        service(0, 16'd7, 16'd8, 1'b1, 16'd16, 1'b0, 1'b0, 1'b1);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        idle_gap(16'd16);
        service(1, 16'd1, 16'd2, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        idle_gap(16'd3);
        @(negedge clk);
        check("final_idle_en", 32'(bus.add_En), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
